// File: rtl/hack_pkg.sv
// Shared types for the Hack PC/branch path: jump-field encoding and the jump condition.
// Default sizes are the reference Hack geometry (32K-word ROM, 8-deep return stack).
package hack_pkg;

  localparam int PC_W_DEF      = 15;
  localparam int RAS_DEPTH_DEF = 8;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [2:0] {
    JNULL = 3'b000,
    JGT   = 3'b001,
    JEQ   = 3'b010,
    JGE   = 3'b011,
    JLT   = 3'b100,
    JNE   = 3'b101,
    JLE   = 3'b110,
    JMP   = 3'b111
  } jump_e;

  // Each jjj bit enables one ALU sign class: bit2 negative, bit1 zero, bit0 positive.
  // zr=ng=1 cannot come from the ALU and is deliberately evaluated literally.
  function automatic logic jump_cond(input logic is_c, input jump_e jjj,
                                     input logic zr, input logic ng);
    return is_c & ((jjj[2] & ng) | (jjj[1] & zr) | (jjj[0] & ~zr & ~ng));
  endfunction

endpackage

// File: rtl/hack_ras.sv
// Circular return-address stack; push overwrites the oldest entry when full, pop when empty is a no-op.
// Single-cycle update; pop has priority over push; ovf/unf are combinational pulses for the caller.
module hack_ras
  import hack_pkg::*;
#(
  parameter int  PC_W      = PC_W_DEF,
  parameter int  RAS_DEPTH = RAS_DEPTH_DEF,
  localparam int CW        = $clog2(RAS_DEPTH + 1),
  localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_vld,
  input  logic [PC_W-1:0] push_dat,
  input  logic            pop_vld,
  output logic [PC_W-1:0] top_dat,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            ovf_pulse,
  output logic            unf_pulse
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(RAS_DEPTH - 1);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PC_W-1:0]  mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;
  logic             full;

  // sp_q is the next free slot; the newest entry sits just below it, modulo depth.
  assign top_idx = (sp_q == '0) ? LAST_IDX : sp_q - PTR_W'(1);
  assign top_dat = mem_q[top_idx];
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;

  assign ovf_pulse = push_vld & ~pop_vld & full;
  assign unf_pulse = pop_vld & empty;

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (pop_vld) begin
      if (!empty) begin
        sp_d  = top_idx;
        cnt_d = cnt_q - CW'(1);
      end
    end else if (push_vld) begin
      mem_d[sp_q] = push_dat;
      sp_d        = (sp_q == LAST_IDX) ? '0 : sp_q + PTR_W'(1);
      if (!full) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hack_branch_pc.sv
// Hack PC/branch unit: priority stall > ret > jump > increment, with call/return stack and stats.
// New pc and taken appear one clock after inputs are sampled; stall freezes all state for that cycle.
module hack_branch_pc
  import hack_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             is_c,
  input  logic [2:0]                       jjj,
  input  logic                             zr,
  input  logic                             ng,
  input  logic [PC_W-1:0]                  target,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             clr_flags,
  output logic [PC_W-1:0]                  pc,
  output logic                             taken,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_ovf,
  output logic                             ras_unf,
  output logic [CNT_W-1:0]                 jump_cnt
);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d;
  logic             ras_ovf_q, ras_ovf_d;
  logic             ras_unf_q, ras_unf_d;

  logic             cond;
  logic             bump;
  logic [PC_W-1:0]  pc_inc;
  logic             push_vld;
  logic             pop_vld;
  logic [PC_W-1:0]  ras_top;
  logic             ras_empty;
  logic             ras_ovf_pulse;
  logic             ras_unf_pulse;

  assign cond   = jump_cond(is_c, jump_e'(jjj), zr, ng);
  assign pc_inc = pc_q + PC_W'(1);

  hack_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (push_vld),
    .push_dat  (pc_inc),
    .pop_vld   (pop_vld),
    .top_dat   (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .ovf_pulse (ras_ovf_pulse),
    .unf_pulse (ras_unf_pulse)
  );

  always_comb begin
    pc_d       = pc_q;
    taken_d    = 1'b0;
    jump_cnt_d = jump_cnt_q;
    push_vld   = 1'b0;
    pop_vld    = 1'b0;
    bump       = 1'b0;
    if (!stall) begin
      if (ret) begin
        // A return on an empty stack falls through to the next instruction.
        pop_vld = 1'b1;
        if (!ras_empty) begin
          pc_d    = ras_top;
          taken_d = 1'b1;
          bump    = 1'b1;
        end else begin
          pc_d = pc_inc;
        end
      end else if (cond) begin
        pc_d     = target;
        taken_d  = 1'b1;
        bump     = 1'b1;
        push_vld = call;
      end else begin
        pc_d = pc_inc;
      end
    end
    if (bump && (jump_cnt_q != '1)) begin
      jump_cnt_d = jump_cnt_q + CNT_W'(1);
    end
  end

  // Kept apart from the mux above: the stack's pulses are derived from push_vld/pop_vld.
  always_comb begin
    ras_ovf_d = (ras_ovf_q & ~clr_flags) | ras_ovf_pulse;
    ras_unf_d = (ras_unf_q & ~clr_flags) | ras_unf_pulse;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      taken_q    <= 1'b0;
      jump_cnt_q <= '0;
      ras_ovf_q  <= 1'b0;
      ras_unf_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      taken_q    <= taken_d;
      jump_cnt_q <= jump_cnt_d;
      ras_ovf_q  <= ras_ovf_d;
      ras_unf_q  <= ras_unf_d;
    end
  end

  assign pc       = pc_q;
  assign taken    = taken_q;
  assign jump_cnt = jump_cnt_q;
  assign ras_ovf  = ras_ovf_q;
  assign ras_unf  = ras_unf_q;

endmodule

// File: tb/tb_hack_branch_pc.sv
// Self-checking bench for hack_branch_pc: jump table vectors, then call/return, overflow,
// stall/priority, wrap/saturation and asynchronous reset sequences.
module tb_hack_branch_pc;

  localparam int PC_W      = 15;
  localparam int RAS_DEPTH = 8;
  localparam int CNT_W     = 4;
  localparam int RC_W      = $clog2(RAS_DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              stall, is_c, zr, ng, call, ret, clr_flags;
  logic [2:0]        jjj;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   pc;
  logic              taken;
  logic [RC_W-1:0]   ras_count;
  logic              ras_ovf, ras_unf;
  logic [CNT_W-1:0]  jump_cnt;

  hack_branch_pc #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .is_c      (is_c),
    .jjj       (jjj),
    .zr        (zr),
    .ng        (ng),
    .target    (target),
    .call      (call),
    .ret       (ret),
    .clr_flags (clr_flags),
    .pc        (pc),
    .taken     (taken),
    .ras_count (ras_count),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf),
    .jump_cnt  (jump_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            stall;
    logic            is_c;
    logic [2:0]      jjj;
    logic            zr;
    logic            ng;
    logic [PC_W-1:0] target;
    logic            call;
    logic            ret;
    logic            clr;
  } stim_t;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             taken;
    logic [RC_W-1:0]  rc;
    logic             ovf;
    logic             unf;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  typedef struct {
    stim_t s;
    logic  jmp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  obs_t exp_q[$];

  logic [PC_W-1:0]  m_pc;
  logic [CNT_W-1:0] m_cnt;
  logic             m_ovf, m_unf;
  logic [PC_W-1:0]  m_ras[$];

  localparam stim_t IDLE = '0;

  function automatic stim_t mk(logic st, logic c, logic [2:0] j, logic z, logic n,
                               logic [PC_W-1:0] t, logic cl, logic r, logic clr);
    stim_t s;
    s = {st, c, j, z, n, t, cl, r, clr};
    return s;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = {pc, taken, ras_count, ras_ovf, ras_unf, jump_cnt};
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h taken=%0b rc=%0d ovf=%0b unf=%0b cnt=%h, expected pc=%h taken=%0b rc=%0d ovf=%0b unf=%0b cnt=%h",
               name, got.pc, got.taken, got.rc, got.ovf, got.unf, got.cnt,
               exp.pc, exp.taken, exp.rc, exp.ovf, exp.unf, exp.cnt);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_ras.delete();
    exp_q.delete();
  endtask

  // Reference behaviour; jmp is the caller's own statement of whether the jump field fires.
  task automatic model_step(input stim_t s, input logic jmp, output obs_t e);
    logic t, so, su;
    t  = 1'b0;
    so = 1'b0;
    su = 1'b0;
    if (!s.stall) begin
      if (s.ret) begin
        if (m_ras.size() > 0) begin
          m_pc = m_ras.pop_back();
          t    = 1'b1;
        end else begin
          m_pc = PC_W'(m_pc + 1);
          su   = 1'b1;
        end
      end else if (jmp) begin
        if (s.call) begin
          if (m_ras.size() == RAS_DEPTH) begin
            void'(m_ras.pop_front());
            so = 1'b1;
          end
          m_ras.push_back(PC_W'(m_pc + 1));
        end
        m_pc = s.target;
        t    = 1'b1;
      end else begin
        m_pc = PC_W'(m_pc + 1);
      end
    end
    if (t && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    m_ovf = (m_ovf & ~s.clr) | so;
    m_unf = (m_unf & ~s.clr) | su;
    e = {m_pc, t, RC_W'(m_ras.size()), m_ovf, m_unf, m_cnt};
  endtask

  task automatic apply(input string name, input stim_t s, input logic jmp);
    obs_t e;
    {stall, is_c, jjj, zr, ng, target, call, ret, clr_flags} = s;
    model_step(s, jmp, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got pc=%h, expected an entry", name, pc);
    end else begin
      check_obs(name, observe(), exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {stall, is_c, jjj, zr, ng, target, call, ret, clr_flags} = IDLE;
    model_reset();
    #1;
    check_obs("reset_state", observe(), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t tbl[25];

  initial begin
    logic [7:0] neg_m, zero_m, pos_m;
    logic [2:0] fzr, fng;
    logic [PC_W-1:0] exp_ret;

    // Which jjj values fire for a negative, zero, or positive ALU result (bit index = jjj).
    neg_m  = 8'hF0;
    zero_m = 8'hCC;
    pos_m  = 8'hAA;
    fzr    = 3'b010;
    fng    = 3'b001;
    for (int j = 0; j < 8; j++) begin
      for (int f = 0; f < 3; f++) begin
        logic jm;
        jm = (f == 0) ? neg_m[j] : (f == 1) ? zero_m[j] : pos_m[j];
        tbl[j*3+f] = '{s: mk(1'b0, 1'b1, 3'(j), fzr[f], fng[f], 15'h00AB, 1'b0, 1'b0, 1'b0), jmp: jm};
      end
    end
    tbl[24] = '{s: mk(1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 15'h00AB, 1'b0, 1'b0, 1'b0), jmp: 1'b0};

    rst = 1'b0;
    do_reset();

    for (int i = 0; i < 25; i++) begin
      apply($sformatf("jtab_jjj%0d_zr%0b_ng%0b_c%0b", tbl[i].s.jjj, tbl[i].s.zr, tbl[i].s.ng, tbl[i].s.is_c),
            tbl[i].s, tbl[i].jmp);
    end

    // Call / return round trip
    do_reset();
    repeat (16) apply("walk", IDLE, 1'b0);
    check_val("walk_pc", 32'(pc), 32'h0010);
    apply("call", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 15'h0100, 1'b1, 1'b0, 1'b0), 1'b1);
    check_val("call_pc", 32'(pc), 32'h0100);
    check_val("call_rc", 32'(ras_count), 32'd1);
    apply("ret", mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0), 1'b0);
    check_val("ret_pc", 32'(pc), 32'h0011);
    check_val("ret_rc", 32'(ras_count), 32'd0);
    check_val("ret_taken", 32'(taken), 32'd1);
    check_val("ret_cnt", 32'(jump_cnt), 32'd2);

    // Overflow, LIFO drain, underflow, flag clear
    do_reset();
    for (int i = 0; i < 9; i++)
      apply("ovf_call", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, PC_W'(32'h200 + i*16), 1'b1, 1'b0, 1'b0), 1'b1);
    check_val("ovf_flag", 32'(ras_ovf), 32'd1);
    check_val("ovf_rc", 32'(ras_count), 32'd8);
    for (int k = 0; k < 8; k++) begin
      apply("drain_ret", mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0), 1'b0);
      exp_ret = PC_W'(32'h201 + (7 - k) * 16);
      check_val($sformatf("lifo_pc%0d", k), 32'(pc), 32'(exp_ret));
    end
    apply("unf_ret", mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0), 1'b0);
    check_val("unf_flag", 32'(ras_unf), 32'd1);
    check_val("unf_pc", 32'(pc), 32'h0202);
    apply("clr_in_stall", mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1), 1'b0);
    check_val("clr_flags", 32'({ras_ovf, ras_unf}), 32'd0);
    apply("set_beats_clr", mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1), 1'b0);
    check_val("set_wins", 32'(ras_unf), 32'd1);

    // Stall and ret-over-call priority
    do_reset();
    apply("idle", IDLE, 1'b0);
    apply("idle", IDLE, 1'b0);
    apply("pri_call", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 15'h0040, 1'b1, 1'b0, 1'b0), 1'b1);
    apply("stall_jmp", mk(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 15'h0077, 1'b0, 1'b0, 1'b0), 1'b1);
    check_val("stall_pc", 32'(pc), 32'h0040);
    check_val("stall_taken", 32'(taken), 32'd0);
    apply("ret_call_jmp", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 15'h0099, 1'b1, 1'b1, 1'b0), 1'b1);
    check_val("pri_pc", 32'(pc), 32'h0003);
    check_val("pri_rc", 32'(ras_count), 32'd0);

    // PC wrap, wrapped return address, counter saturation
    do_reset();
    apply("to_top", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 15'h7FFF, 1'b0, 1'b0, 1'b0), 1'b1);
    apply("wrap", IDLE, 1'b0);
    check_val("wrap_pc", 32'(pc), 32'h0000);
    apply("to_top", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 15'h7FFF, 1'b0, 1'b0, 1'b0), 1'b1);
    apply("call_top", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 15'h0005, 1'b1, 1'b0, 1'b0), 1'b1);
    apply("ret_wrap", mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0), 1'b0);
    check_val("ret_wrap_pc", 32'(pc), 32'h0000);
    repeat (18) apply("sat_jmp", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, PC_W'($urandom), 1'b0, 1'b0, 1'b0), 1'b1);
    check_val("sat_cnt", 32'(jump_cnt), 32'h000F);

    // Asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++)
      apply("pre_rst_call", mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, PC_W'(32'h300 + i), 1'b1, 1'b0, 1'b0), 1'b1);
    check_val("pre_rst_rc", 32'(ras_count), 32'd3);
    #2;
    rst = 1'b1;
    {stall, is_c, jjj, zr, ng, target, call, ret, clr_flags} = IDLE;
    #1;
    check_obs("async_reset", observe(), '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply("post_rst", IDLE, 1'b0);
    check_val("post_rst_pc", 32'(pc), 32'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
